int_divide_stage: RTL

//  Parametrised multi-cycle vector integer divide/remainder unit, sibling of the single-cycle

---
 rtl/int_divide_stage_pkg.sv | 31 +++
 rtl/int_divide_stage_lane.sv | 100 ++++++++++
 rtl/int_divide_stage.sv | 131 +++++++++++++
 3 files changed

// File: rtl/int_divide_stage_pkg.sv
// Shared definitions for the multi-cycle vector divide stage: operation
// encoding, vector/thread typedefs and small decode helpers.
package int_divide_stage_pkg;

  localparam int DEFAULT_NUM_LANES        = 16;
  localparam int DEFAULT_DATA_WIDTH       = 32;
  localparam int DEFAULT_THREAD_IDX_WIDTH = 2;

  typedef enum logic [1:0] {
    DIV_S = 2'd0,
    DIV_U = 2'd1,
    REM_S = 2'd2,
    REM_U = 2'd3
  } div_op_t;

  typedef logic [DEFAULT_DATA_WIDTH-1:0]       scalar_t;
  typedef scalar_t [DEFAULT_NUM_LANES-1:0]     vector_t;
  typedef logic [DEFAULT_NUM_LANES-1:0]        vector_mask_t;
  typedef logic [DEFAULT_THREAD_IDX_WIDTH-1:0] local_thread_idx_t;

  // Signed ops take two's-complement magnitudes and need a sign fix-up.
  function automatic logic op_is_signed(input div_op_t op);
    return (op == DIV_S) || (op == REM_S);
  endfunction

  // Remainder ops return the partial remainder instead of the quotient.
  function automatic logic op_is_rem(input div_op_t op);
    return (op == REM_S) || (op == REM_U);
  endfunction

endpackage

// File: rtl/int_divide_stage_lane.sv
// One lane of the restoring divider: captures operand magnitudes and signs
// at start, retires one quotient bit per step, and presents the sign-fixed
// quotient or remainder combinationally once all bits are done.
module int_divide_lane
  import int_divide_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  step,
  input  logic                  active,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  div_zero
);

  logic                  is_signed_q;
  logic                  is_rem_q;
  logic                  sign_a_q;
  logic                  sign_b_q;
  logic                  zero_q;
  logic [DATA_WIDTH-1:0] dividend_q;
  logic [DATA_WIDTH-1:0] divisor_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [DATA_WIDTH-1:0] rem_q;

  logic                  op_signed;
  logic                  a_neg;
  logic                  b_neg;
  logic [DATA_WIDTH-1:0] mag_a;
  logic [DATA_WIDTH-1:0] mag_b;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   trial;
  logic                  no_borrow;
  logic [DATA_WIDTH-1:0] quo_fix;
  logic [DATA_WIDTH-1:0] rem_fix;

  // Operand decode at issue: magnitudes for signed ops, raw values otherwise.
  always_comb begin
    op_signed = op_is_signed(div_op_t'(op));
    a_neg     = op_signed && operand1[DATA_WIDTH-1];
    b_neg     = op_signed && operand2[DATA_WIDTH-1];
    mag_a     = a_neg ? (~operand1 + 1'b1) : operand1;
    mag_b     = b_neg ? (~operand2 + 1'b1) : operand2;
  end

  // Trial subtraction: next dividend bit shifted into the partial remainder.
  // The remainder stays below the divisor, so the shifted value fits in
  // DATA_WIDTH+1 bits and a magnitude compare gives the borrow.
  always_comb begin
    shifted   = {rem_q, quo_q[DATA_WIDTH-1]};
    trial     = shifted - {1'b0, divisor_q};
    no_borrow = (shifted >= {1'b0, divisor_q});
  end

  // Operand capture on start, one restoring step per cycle while stepping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      is_signed_q <= 1'b0;
      is_rem_q    <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      zero_q      <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
    end else if (start) begin
      is_signed_q <= op_signed;
      is_rem_q    <= op_is_rem(div_op_t'(op));
      sign_a_q    <= a_neg;
      sign_b_q    <= b_neg;
      zero_q      <= (operand2 == '0);
      dividend_q  <= operand1;
      divisor_q   <= mag_b;
      quo_q       <= mag_a;
      rem_q       <= '0;
    end else if (step) begin
      rem_q <= no_borrow ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
      quo_q <= {quo_q[DATA_WIDTH-2:0], no_borrow};
    end
  end

  // Sign fix-up, zero-divisor override and lane masking of the final value.
  always_comb begin
    quo_fix = (is_signed_q && (sign_a_q ^ sign_b_q)) ? (~quo_q + 1'b1) : quo_q;
    rem_fix = (is_signed_q && sign_a_q) ? (~rem_q + 1'b1) : rem_q;
    if (zero_q) begin
      quo_fix = '1;
      rem_fix = dividend_q;
    end
    result   = active ? (is_rem_q ? rem_fix : quo_fix) : '0;
    div_zero = active && zero_q;
  end

endmodule

// File: rtl/int_divide_stage.sv
// Multi-cycle vector integer divide/remainder stage. A small FSM
// (IDLE -> RUN -> FINISH) sequences DATA_WIDTH restoring steps across all
// lanes in lockstep and emits a one-cycle result strobe.
//
// Handshake: an op is taken on a rising edge where the unit is idle,
// of_instruction_valid is high and the issuing thread is not being rolled
// back in the same cycle; dv_busy (combinational from state) tells thread
// select not to issue, and ops presented while busy are dropped.
// dv_instruction_valid is a single-cycle strobe with no back-pressure.
module int_divide_stage
  import int_divide_stage_pkg::*;
#(
  parameter int NUM_LANES        = DEFAULT_NUM_LANES,
  parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH,
  parameter int THREAD_IDX_WIDTH = DEFAULT_THREAD_IDX_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            of_instruction_valid,
  input  logic [1:0]                      of_div_op,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] of_operand1,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] of_operand2,
  input  logic [NUM_LANES-1:0]            of_mask_value,
  input  logic [THREAD_IDX_WIDTH-1:0]     of_thread_idx,
  input  logic                            wb_rollback_en,
  input  logic [THREAD_IDX_WIDTH-1:0]     wb_rollback_thread_idx,
  output logic                            dv_busy,
  output logic                            dv_instruction_valid,
  output logic [NUM_LANES*DATA_WIDTH-1:0] dv_result,
  output logic [NUM_LANES-1:0]            dv_mask_value,
  output logic [THREAD_IDX_WIDTH-1:0]     dv_thread_idx,
  output logic [NUM_LANES-1:0]            dv_div_zero_mask
);

  localparam logic [1:0] STATE_IDLE   = 2'd0;
  localparam logic [1:0] STATE_RUN    = 2'd1;
  localparam logic [1:0] STATE_FINISH = 2'd2;

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);

  // Observable FSM state for checkers.
  logic [1:0]                      state;
  logic [CNT_W-1:0]                counter;
  logic [NUM_LANES-1:0]            mask_q;
  logic [THREAD_IDX_WIDTH-1:0]     thread_q;

  logic                            accept;
  logic                            rollback_hit;
  logic                            lane_step;
  logic [NUM_LANES*DATA_WIDTH-1:0] lane_result;
  logic [NUM_LANES-1:0]            lane_zero;

  // Issue/flush decode and busy indication.
  always_comb begin
    rollback_hit = wb_rollback_en && (wb_rollback_thread_idx == thread_q);
    accept       = (state == STATE_IDLE) && of_instruction_valid &&
                   !(wb_rollback_en && (wb_rollback_thread_idx == of_thread_idx));
    lane_step    = (state == STATE_RUN) && !rollback_hit;
    dv_busy      = (state != STATE_IDLE);
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      int_divide_lane #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_lane (
        .clk      (clk),
        .reset    (reset),
        .start    (accept),
        .step     (lane_step),
        .active   (mask_q[g]),
        .op       (of_div_op),
        .operand1 (of_operand1[g*DATA_WIDTH +: DATA_WIDTH]),
        .operand2 (of_operand2[g*DATA_WIDTH +: DATA_WIDTH]),
        .result   (lane_result[g*DATA_WIDTH +: DATA_WIDTH]),
        .div_zero (lane_zero[g])
      );
    end
  endgenerate

  // Sequencing FSM, step counter and result registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state                <= STATE_IDLE;
      counter              <= '0;
      mask_q               <= '0;
      thread_q             <= '0;
      dv_instruction_valid <= 1'b0;
      dv_result            <= '0;
      dv_mask_value        <= '0;
      dv_thread_idx        <= '0;
      dv_div_zero_mask     <= '0;
    end else begin
      dv_instruction_valid <= 1'b0;
      case (state)
        STATE_IDLE: begin
          if (accept) begin
            state    <= STATE_RUN;
            counter  <= '0;
            mask_q   <= of_mask_value;
            thread_q <= of_thread_idx;
          end
        end
        STATE_RUN: begin
          if (rollback_hit) begin
            state <= STATE_IDLE;
          end else begin
            counter <= counter + CNT_W'(1);
            if (counter == LAST_STEP) begin
              state <= STATE_FINISH;
            end
          end
        end
        STATE_FINISH: begin
          state <= STATE_IDLE;
          if (!rollback_hit) begin
            dv_instruction_valid <= 1'b1;
            dv_result            <= lane_result;
            dv_mask_value        <= mask_q;
            dv_thread_idx        <= thread_q;
            dv_div_zero_mask     <= lane_zero;
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

endmodule
